// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: circular buffer with first-word fall-through
// read, registered status and a sticky overrun flag. Optional IRQ via UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Rx_DV,
  input  logic              i_Rd_En,
  input  logic              i_Clr_Ovr,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Empty,
  output logic              o_Full,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overrun,
  output logic              o_Irq
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overrun;

  logic              w_pop;
  logic              w_push;
  logic              w_ovr;
  logic              w_ovr_nxt;
  logic [ADDR_W:0]   w_count_nxt;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a byte.
  assign w_pop     = i_Rd_En & ~r_empty;
  assign w_push    = i_Rx_DV & (~r_full | w_pop);
  assign w_ovr     = i_Rx_DV & r_full & ~w_pop;
  assign w_ovr_nxt = w_ovr | (r_overrun & ~i_Clr_Ovr);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_Rx_Byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_nxt;
      r_empty   <= (w_count_nxt == '0);
      r_full    <= (w_count_nxt == LP_DEPTH);
      r_overrun <= w_ovr_nxt;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [ADDR_W:0] LP_THRESH = (ADDR_W+1)'(IRQ_THRESH);
  logic r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= (w_count_nxt >= LP_THRESH) | w_ovr_nxt;
  end

  assign o_Irq = r_irq;
`else
  assign o_Irq = 1'b0;
`endif

  assign o_Rd_Data = r_mem[r_rd_ptr];
  assign o_Empty   = r_empty;
  assign o_Full    = r_full;
  assign o_Count   = r_count;
  assign o_Overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge
// monitor checks popped data and status against a small occupancy model.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int THRESH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        i_Rx_Byte;
  logic              i_Rx_DV;
  logic              i_Rd_En;
  logic              i_Clr_Ovr;
  logic [7:0]        o_Rd_Data;
  logic              o_Empty;
  logic              o_Full;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overrun;
  logic              o_Irq;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IRQ_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .i_Rx_Byte(i_Rx_Byte), .i_Rx_DV(i_Rx_DV),
    .i_Rd_En(i_Rd_En), .i_Clr_Ovr(i_Clr_Ovr), .o_Rd_Data(o_Rd_Data),
    .o_Empty(o_Empty), .o_Full(o_Full), .o_Count(o_Count),
    .o_Overrun(o_Overrun), .o_Irq(o_Irq)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         m_count = 0;
  bit         m_ovr = 0;
  int         last_popped = -1;
  bit         done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT accepts a read; checks status each cycle.
  always @(negedge clk) begin
    if (!done) begin
      int exp_irq;
`ifdef UART_RX_FIFO_IRQ_EN
      exp_irq = ((m_count >= THRESH) || m_ovr) ? 1 : 0;
`else
      exp_irq = 0;
`endif
      chk("count", int'(o_Count), m_count);
      chk("empty", int'(o_Empty), (m_count == 0) ? 1 : 0);
      chk("full", int'(o_Full), (m_count == DEPTH) ? 1 : 0);
      chk("overrun", int'(o_Overrun), int'(m_ovr));
      chk("irq", int'(o_Irq), exp_irq);
      if (i_Rd_En && !o_Empty && !reset) begin
        if (exp_q.size() == 0) begin
          chk("pop_underflow", int'(o_Rd_Data), -1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rd_data", int'(o_Rd_Data), int'(e));
          last_popped = int'(o_Rd_Data);
        end
      end
    end
  end

  // One clock cycle of stimulus; the model tracks what the DUT should do.
  task automatic step(input bit dv, input logic [7:0] b, input bit rd, input bit clr);
    bit pop, push, ovr;
    i_Rx_DV = dv; i_Rx_Byte = b; i_Rd_En = rd; i_Clr_Ovr = clr;
    pop  = rd && (m_count > 0);
    push = dv && ((m_count < DEPTH) || pop);
    ovr  = dv && (m_count == DEPTH) && !pop;
    if (push) exp_q.push_back(b);
    @(posedge clk);
    #1;
    m_count = m_count + int'(push) - int'(pop);
    if (ovr) m_ovr = 1;
    else if (clr) m_ovr = 0;
    i_Rx_DV = 0; i_Rx_Byte = 8'h00; i_Rd_En = 0; i_Clr_Ovr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    exp_q.delete();
    m_count = 0;
    m_ovr = 0;
    #1;
    chk("async_rst_count", int'(o_Count), 0);
    chk("async_rst_empty", int'(o_Empty), 1);
    chk("async_rst_full", int'(o_Full), 0);
    chk("async_rst_ovr", int'(o_Overrun), 0);
    chk("async_rst_irq", int'(o_Irq), 0);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 1; i_Rx_Byte = 0; i_Rx_DV = 0; i_Rd_En = 0; i_Clr_Ovr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // 1: three spaced pushes, then three pops
    foreach (exp_q[i]) ;
    step(1, 8'h41, 0, 0); idle(4);
    step(1, 8'h42, 0, 0); idle(4);
    step(1, 8'h43, 0, 0); idle(4);
    chk("t1_count3", int'(o_Count), 3);
    chk("t1_head", int'(o_Rd_Data), 8'h41);
    step(0, 0, 1, 0); chk("t1_head2", int'(o_Rd_Data), 8'h42);
    step(0, 0, 1, 0); chk("t1_head3", int'(o_Rd_Data), 8'h43);
    step(0, 0, 1, 0); idle(1);
    chk("t1_empty", int'(o_Empty), 1);

    // 2: fill, overrun, drain, clear
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    chk("t2_full", int'(o_Full), 1);
    chk("t2_count16", int'(o_Count), 16);
    step(1, 8'hAA, 0, 0);
    chk("t2_ovr_set", int'(o_Overrun), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    chk("t2_last", last_popped, 8'h0F);
    step(0, 0, 0, 1);
    chk("t2_ovr_clr", int'(o_Overrun), 0);

    // 3: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0, 0);
    step(1, 8'h55, 1, 0);
    chk("t3_no_ovr", int'(o_Overrun), 0);
    chk("t3_count16", int'(o_Count), 16);
    // clear and new overrun together: set wins
    step(1, 8'hBB, 0, 1);
    chk("t3_set_wins", int'(o_Overrun), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    chk("t3_last55", last_popped, 8'h55);
    step(0, 0, 0, 1);

    // 4: pop while empty, then streaming push/pop with pointer wrap
    step(0, 0, 1, 0);
    chk("t4_empty_pop", int'(o_Count), 0);
    step(1, 8'h60, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h61 + i), 1, 0);
    chk("t4_count1", int'(o_Count), 1);
    step(0, 0, 1, 0);

    // 5: async reset with 7 stored bytes
    for (int i = 0; i < 7; i++) step(1, 8'(8'hC0 + i), 0, 0);
    chk("t5_count7", int'(o_Count), 7);
    do_reset();
    step(1, 8'h99, 0, 0);
    chk("t5_head99", int'(o_Rd_Data), 8'h99);
    step(0, 0, 1, 0);

    // 6: interrupt threshold (the monitor checks o_Irq every cycle)
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0);
    chk("t6_irq3", int'(o_Irq), 0);
    step(1, 8'h73, 0, 0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("t6_irq4", int'(o_Irq), 1);
`else
    chk("t6_irq4", int'(o_Irq), 0);
`endif
    step(0, 0, 1, 0);
    chk("t6_irq_pop", int'(o_Irq), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    idle(2);

    chk("sb_drained", exp_q.size(), 0);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
